pipeline_sequencer: RTL
=======================

// Module: pipeline_sequencer
// PURPOSE
//  Run controller for the 5-stage MIPS pipeline (IF/ID/EX/MEM/WB).
//  Gates the shared pipeline-register enable and the PC enable, in continuous-run or single-step mode.
//  Detects the HALT opcode in IF, freezes the PC, drains in-flight instructions to WB, then reports done.
//  Sits between the debug/UART front-end (start/step/abort) and every pipeline stage register.
// PARAMETERS
//  NB_OPCODE    6          opcode width
//  HALT_OPCODE  6'b111111  opcode that ends the program
//  PIPE_DEPTH   5          pipeline stages; drain length is PIPE_DEPTH-1 cycles
//  NB_CYCLES    32         width of the executed-cycle counter
// PORTS
//  i_clk          in   1          system clock, rising edge
//  i_reset        in   1          asynchronous, active-low reset
//  i_start        in   1          1-cycle pulse: begin program (from IDLE or DONE)
//  i_mode         in   1          sampled with i_start: 0 = continuous, 1 = single-step
//  i_step         in   1          1-cycle pulse: advance one cycle (step mode only)
//  i_abort        in   1          return to IDLE from any state
//  i_if_opcode    in   NB_OPCODE  opcode of the instruction currently in IF
//  o_pipe_enable  out  1          enable for all stage registers this cycle
//  o_pc_enable    out  1          PC update enable this cycle
//  o_busy         out  1          1 in RUN, STEP_WAIT, STEP_EXEC, DRAIN
//  o_done         out  1          sticky: program finished
//  o_cycle_count  out  NB_CYCLES  number of cycles with o_pipe_enable=1 since last start
//  o_state        out  3          state encoding, for debug readout
// BEHAVIOUR
//  Reset (i_reset=0, async): state IDLE, all outputs 0, drain counter 0, o_cycle_count 0.
//  States: IDLE=0, RUN=1, STEP_WAIT=2, STEP_EXEC=3, DRAIN=4, DONE=5.
//  halt = (i_if_opcode == HALT_OPCODE).
//  o_pipe_enable/o_pc_enable are combinational from state and halt. All other outputs are registered.
//  IDLE: enables 0.
//    i_start with i_mode=0 -> RUN. i_start with i_mode=1 -> STEP_WAIT.
//    Either start clears o_cycle_count and o_done.
//  RUN: pipe_enable=1, pc_enable=!halt.
//    On halt, the PC holds at HALT; load drain counter with PIPE_DEPTH-1; -> DRAIN.
//  STEP_WAIT: enables 0. i_step -> STEP_EXEC. i_start is ignored.
//  STEP_EXEC: exactly one cycle; pipe_enable=1, pc_enable=!halt.
//    halt -> DRAIN (loads counter); else -> STEP_WAIT.
//    i_step here is ignored; it is not queued.
//  DRAIN: pipe_enable=1, pc_enable=0. Runs freely in both modes.
//    Re-fetched HALT words flow downstream as NOPs.
//    Counter decrements each cycle; when the counter is 1 -> DONE next cycle.
//    Total DRAIN cycles = PIPE_DEPTH-1.
//  DONE: enables 0, o_done=1. i_start restarts as from IDLE.
//  o_cycle_count increments on every cycle with o_pipe_enable=1 and saturates at all-ones (no wrap).
//  Priority: i_abort > i_start > i_step.
//    i_abort in any state -> IDLE next cycle, o_done=0, o_cycle_count held.
//    i_start while busy is ignored. i_step outside STEP_WAIT is ignored.
//  Halt fetched on the very first RUN cycle: valid. Result is 1 RUN cycle + PIPE_DEPTH-1 DRAIN cycles.
//  Reset asserted mid-DRAIN: immediate return to IDLE; no partial done.
// TESTING
//  1) start(mode 0), opcodes non-halt x3 then HALT -> pc_enable low on cycle 4;
//     4 DRAIN cycles; o_done=1; o_cycle_count=8.
//  2) start(mode 1), 3 i_step pulses 5 cycles apart (no halt)
//     -> exactly 3 single-cycle pipe_enable pulses; count=3; state returns to 2.
//  3) step mode, HALT in IF at 2nd step -> DRAIN runs 4 cycles without steps -> DONE, count=6.
//  4) i_abort in DRAIN -> IDLE next cycle, enables 0, o_done=0.
//     Same-cycle i_start+i_abort in IDLE -> stays IDLE.
//  5) NB_CYCLES=4, run 20 cycles without halt -> o_cycle_count sticks at 15.
//  6) Drop i_reset asynchronously mid-RUN (between edges) -> all outputs 0 before the next edge.
//     i_start after DONE -> o_done=0, count=0, RUN.

Source files
------------

// File: rtl/pipeline_sequencer_if.sv
// Purpose  : control/status bundle between the debug front-end and the pipeline run controller.
// Latency  : wires only; timing is defined by pipeline_sequencer.
// Backpress: none; i_start/i_step/i_abort are single-cycle requests with no acknowledge.
// Ports    : master = front-end (drives i_* requests and opcode tap), slave = sequencer (drives o_* status).
interface pipeline_sequencer_if #(
  parameter int NB_OPCODE = 6,
  parameter int NB_CYCLES = 32
);
  logic                 i_start;
  logic                 i_mode;
  logic                 i_step;
  logic                 i_abort;
  logic [NB_OPCODE-1:0] i_if_opcode;
  logic                 o_pipe_enable;
  logic                 o_pc_enable;
  logic                 o_busy;
  logic                 o_done;
  logic [NB_CYCLES-1:0] o_cycle_count;
  logic [2:0]           o_state;

  modport master (
    output i_start, i_mode, i_step, i_abort, i_if_opcode,
    input  o_pipe_enable, o_pc_enable, o_busy, o_done, o_cycle_count, o_state
  );

  modport slave (
    input  i_start, i_mode, i_step, i_abort, i_if_opcode,
    output o_pipe_enable, o_pc_enable, o_busy, o_done, o_cycle_count, o_state
  );
endinterface

// File: rtl/pipeline_sequencer.sv
// Purpose  : run/step controller for the 5-stage pipeline; stops the PC on HALT, drains, flags done.
// Latency  : pipe/pc enables are combinational from state+halt; busy/done/count/state update one cycle later.
// Backpress: none; requests arriving in a state that cannot take them are dropped, never queued.
// Ports    : i_clk, i_reset (async active-low), bus (slave modport: start/mode/step/abort/opcode in,
//            pipe_enable/pc_enable/busy/done/cycle_count/state out).
module pipeline_sequencer #(
  parameter int                 NB_OPCODE   = 6,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = '1,
  parameter int                 PIPE_DEPTH  = 5,
  parameter int                 NB_CYCLES   = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  pipeline_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RUN       = 3'd1,
    ST_STEP_WAIT = 3'd2,
    ST_STEP_EXEC = 3'd3,
    ST_DRAIN     = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  localparam int                  NB_DRAIN   = $clog2(PIPE_DEPTH) + 1;
  localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(PIPE_DEPTH - 1);

  state_t               state_q, state_d;
  logic [NB_DRAIN-1:0]  drain_q, drain_d;
  logic [NB_CYCLES-1:0] count_q, count_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic halt;
  logic pipe_enable;
  logic pc_enable;

  assign halt = (bus.i_if_opcode == HALT_OPCODE);

  // Enables follow the current state directly so the stage registers see them in the same cycle.
  always_comb begin
    pipe_enable = 1'b0;
    pc_enable   = 1'b0;
    case (state_q)
      ST_RUN, ST_STEP_EXEC: begin
        pipe_enable = 1'b1;
        pc_enable   = !halt;     // PC parks on the HALT word
      end
      ST_DRAIN: pipe_enable = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = done_q;
    count_d = count_q;

    // Saturating count of enabled cycles; a restart may override this below.
    if (pipe_enable && (count_q != '1))
      count_d = count_q + NB_CYCLES'(1);

    if (bus.i_abort) begin
      // Abort keeps the count for debug readout but forgets any finished run.
      state_d = ST_IDLE;
      done_d  = 1'b0;
      drain_d = '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.i_start) begin
            state_d = bus.i_mode ? ST_STEP_WAIT : ST_RUN;
            count_d = '0;
            done_d  = 1'b0;
          end
        end
        ST_RUN: begin
          if (halt) begin
            drain_d = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end
        end
        ST_STEP_WAIT: begin
          if (bus.i_step)
            state_d = ST_STEP_EXEC;
        end
        ST_STEP_EXEC: begin
          if (halt) begin
            drain_d = DRAIN_LOAD;
            state_d = ST_DRAIN;
          end else begin
            state_d = ST_STEP_WAIT;
          end
        end
        ST_DRAIN: begin
          // Counter value 1 marks the last drain cycle; <= also covers a depth-1 pipe.
          drain_d = (drain_q != '0) ? drain_q - NB_DRAIN'(1) : '0;
          if (drain_q <= NB_DRAIN'(1)) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_STEP_WAIT) ||
             (state_d == ST_STEP_EXEC) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      drain_q <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.o_pipe_enable = pipe_enable;
  assign bus.o_pc_enable   = pc_enable;
  assign bus.o_busy        = busy_q;
  assign bus.o_done        = done_q;
  assign bus.o_cycle_count = count_q;
  assign bus.o_state       = state_q;

endmodule
